// File: rtl/bcd_store_ctrl.sv
// FX33 (LD B,Vx) sequencer: converts Vx to three BCD digits and writes them to memory at I..I+2.
// Optional BCD_STORE_ITERATIVE_EN selects a serial 8-cycle double-dabble instead of combinational conversion.
module bcd_store_ctrl #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        vx,
  input  logic [ADDR_W-1:0] index,
  output logic              busy,
  output logic              done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_gnt
);

  typedef enum logic [2:0] {IDLE, CONV, WR0, WR1, WR2, DONE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] index_q;
  logic [11:0]       bcd;
  logic [1:0]        off;
  logic [3:0]        digit;

  // One double-dabble step on {hundreds, tens, ones, binary}: add-3 then shift left.
  function automatic logic [19:0] dd_step(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    for (int unsigned i = 0; i < 3; i++) begin
      if (t[8+4*i +: 4] >= 4'd5)
        t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

`ifdef BCD_STORE_ITERATIVE_EN
  logic [19:0] sr;
  logic [2:0]  cnt;

  assign bcd = sr[19:8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index_q <= '0;
      sr      <= '0;
      cnt     <= '0;
    end else if (state == IDLE && start) begin
      index_q <= index;
      sr      <= {12'h000, vx};
      cnt     <= '0;
    end else if (state == CONV) begin
      sr  <= dd_step(sr);
      cnt <= cnt + 3'd1;
    end
  end
`else
  logic [11:0] bcd_q;

  function automatic logic [11:0] bin2bcd(input logic [7:0] v);
    logic [19:0] s;
    s = {12'h000, v};
    for (int unsigned i = 0; i < 8; i++) s = dd_step(s);
    return s[19:8];
  endfunction

  assign bcd = bcd_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index_q <= '0;
      bcd_q   <= '0;
    end else if (state == IDLE && start) begin
      index_q <= index;
      bcd_q   <= bin2bcd(vx);
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) begin
`ifdef BCD_STORE_ITERATIVE_EN
        state_nx = CONV;
`else
        state_nx = WR0;
`endif
      end
`ifdef BCD_STORE_ITERATIVE_EN
      CONV: if (cnt == 3'd7) state_nx = WR0;
`endif
      WR0:  if (mem_gnt) state_nx = WR1;
      WR1:  if (mem_gnt) state_nx = WR2;
      WR2:  if (mem_gnt) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    mem_we    = 1'b0;
    off       = 2'd0;
    digit     = 4'h0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      WR0: begin mem_we = 1'b1; off = 2'd0; digit = bcd[11:8]; end
      WR1: begin mem_we = 1'b1; off = 2'd1; digit = bcd[7:4];  end
      WR2: begin mem_we = 1'b1; off = 2'd2; digit = bcd[3:0];  end
      default: ;
    endcase
    if (mem_we) begin
      mem_addr  = index_q + ADDR_W'(off);
      mem_wdata = {4'h0, digit};
    end
  end

endmodule

// File: tb/tb_bcd_store_ctrl.sv
// Directed bench for bcd_store_ctrl: write sequences, wrap, grant stalls, ignored starts and reset abort.
module tb_bcd_store_ctrl;
  localparam int unsigned ADDR_W = 12;
`ifdef BCD_STORE_ITERATIVE_EN
  localparam int LAT = 11;
`else
  localparam int LAT = 3;
`endif

  logic              clk, reset_n, start, busy, done, mem_we, mem_gnt;
  logic [7:0]        vx, mem_wdata;
  logic [ADDR_W-1:0] index, mem_addr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [19:0] wr_q[$];

  bcd_store_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .vx(vx), .index(index),
    .busy(busy), .done(done), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record accepted writes just before each rising edge.
  always @(negedge clk) begin
    #4;
    if (reset_n && mem_we && mem_gnt) wr_q.push_back({mem_addr, mem_wdata});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_writes(input string tag, input logic [ADDR_W-1:0] idx,
                              input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2);
    logic [3:0]  d[3];
    logic [19:0] got;
    d[0] = d0; d[1] = d1; d[2] = d2;
    check({tag, "_nwr"}, wr_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      got = (i < wr_q.size()) ? wr_q[i] : 20'hFFFFF;
      check($sformatf("%s_w%0d", tag, i), got, {idx + ADDR_W'(i), 4'h0, d[i]});
    end
  endtask

  // Issues one start and waits for done; lat counts falling edges after the start pulse ends.
  task automatic run_op(input string tag, input logic [7:0] v, input logic [ADDR_W-1:0] idx,
                        input bit inject, output int lat);
    wr_q.delete();
    @(negedge clk); vx = v; index = idx; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    if (inject) begin start = 1'b1; vx = 8'd77; index = 12'h555; end
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = c;
        if (inject) begin start = 1'b1; vx = 8'd99; index = 12'h777; end
        break;
      end
    end
    @(negedge clk); start = 1'b0;
    check({tag, "_done1"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  int lat;
  bit found;
  int c;

  initial begin
    reset_n = 1'b0; start = 1'b0; vx = '0; index = '0; mem_gnt = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_out", {busy, done, mem_we, mem_addr, mem_wdata}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op("t1", 8'd255, 12'h300, 0, lat);
    check("t1_lat", lat, LAT);
    check_writes("t1", 12'h300, 4'd2, 4'd5, 4'd5);

    run_op("t2a", 8'd0, 12'h010, 0, lat);
    check_writes("t2a", 12'h010, 4'd0, 4'd0, 4'd0);
    run_op("t2b", 8'd9, 12'h020, 0, lat);
    check_writes("t2b", 12'h020, 4'd0, 4'd0, 4'd9);
    run_op("t2c", 8'd100, 12'h030, 0, lat);
    check_writes("t2c", 12'h030, 4'd1, 4'd0, 4'd0);

    for (int v = 0; v < 256; v++) begin
      run_op("sw", 8'(v), 12'(v * 5), 0, lat);
      check_writes($sformatf("sw%0d", v), 12'(v * 5),
                   4'(v / 100), 4'((v / 10) % 10), 4'(v % 10));
    end

    run_op("t3", 8'd123, 12'hFFE, 0, lat);
    check_writes("t3", 12'hFFE, 4'd1, 4'd2, 4'd3);
    check("t3_w2abs", wr_q.size() > 2 ? wr_q[2] : 20'hFFFFF, 20'h00003);
    run_op("t3b", 8'd42, 12'hFFF, 0, lat);
    check_writes("t3b", 12'hFFF, 4'd0, 4'd4, 4'd2);

    // Grant withheld for three cycles while the tens digit is pending.
    wr_q.delete();
    @(negedge clk); vx = 8'd147; index = 12'h0A0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    c = 0; found = 0;
    for (int k = 0; k < 30; k++) begin
      if (mem_we && mem_addr == 12'h0A1) begin found = 1; break; end
      @(negedge clk); c++;
    end
    check("t4_reach", found, 1);
    mem_gnt = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check($sformatf("t4_we%0d", j), mem_we, 1);
      check($sformatf("t4_addr%0d", j), mem_addr, 12'h0A1);
      check($sformatf("t4_data%0d", j), mem_wdata, 8'h04);
      @(negedge clk); c++;
    end
    mem_gnt = 1'b1;
    found = 0;
    for (int k = 0; k < 30; k++) begin
      if (done) begin found = 1; break; end
      @(negedge clk); c++;
    end
    check("t4_done", found, 1);
    check("t4_lat", c, LAT + 3);
    @(negedge clk);
    check_writes("t4", 12'h0A0, 4'd1, 4'd4, 4'd7);

    run_op("t5", 8'd58, 12'h123, 1, lat);
    check("t5_lat", lat, LAT);
    repeat (20) @(negedge clk);
    check("t5_idle", busy, 0);
    check_writes("t5", 12'h123, 4'd0, 4'd5, 4'd8);

    // Reset asserted while the second write is pending.
    wr_q.delete();
    @(negedge clk); vx = 8'd88; index = 12'h200; start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int k = 0; k < 30; k++) begin
      if (mem_we && mem_addr == 12'h201) begin found = 1; break; end
      @(negedge clk);
    end
    check("t6_reach", found, 1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_out", {busy, done, mem_we, mem_addr, mem_wdata}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t6_nwr", wr_q.size(), 1);
    check("t6_idle", busy, 0);
    run_op("t6b", 8'd88, 12'h200, 0, lat);
    check("t6b_lat", lat, LAT);
    check_writes("t6b", 12'h200, 4'd0, 4'd8, 4'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
